phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Timing generator for the multi-cycle MIPS core. Sits directly upstream of the control unit and drives its one-hot phase vector p[4:0] (p0 fetch, p1 decode, p2 execute/address, p3 memory, p4 writeback).
- Owns the instruction register and drives op/irfunc to the control unit.
- Selects the phase path per instruction class and stalls on the memory handshake.
- Halts on illegal opcodes or memory timeout.

Parameters:
- MAX_WAIT, 15, cycles a phase may wait for mem_ready before a bus-error halt (1..255).
- CNT_W, 32, width of the cycle and retired-instruction counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  start/continue execution; sampled only at instruction boundaries
- mem_ready  in  1  memory access complete in the current phase
- instr_rdata  in  32  instruction memory read data
- p  out  5  one-hot phase to the control unit; 5'b00000 when idle or halted
- op  out  6  ir[31:26]
- irfunc  out  6  ir[5:0]
- ir  out  32  instruction register
- busy  out  1  an instruction is in flight
- halted  out  1  sticky halt
- halt_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout
- cycle_cnt  out  CNT_W  cycles spent in any phase, wraps at 2^CNT_W
- instr_cnt  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async) values: p=0, ir=0, busy=0, halted=0, halt_cause=00, both counters 0, internal wait counter 0, state IDLE.
- States: IDLE, P0..P4, HALT. p is a registered one-hot copy of P0..P4 and is zero in IDLE and HALT.
- IDLE: go to P0 next cycle if run=1 and halted=0, otherwise stay.
- P0 (fetch): stay while mem_ready=0. On mem_ready=1, ir <= instr_rdata at that edge and go to P1.
- P1 (decode), classify ir[31:26] and funct:
  - add: op 000000 with funct 100000
  - lw: 100011
  - sw: 101011
  - j: 000010
  - jal: 000011
  - Any other encoding goes to HALT with cause 01. Legal instructions go to P2.
- P2: go to P3 for lw/sw; go to P4 for add/j/jal.
- P3: stay while mem_ready=0. On mem_ready=1: lw goes to P4; sw retires.
  - sw never enters P4, because the control unit asserts regwrite unconditionally in p4.
- P4: always one cycle, then retire.
- Retire: instr_cnt+1. Then go to P0 if run=1, or IDLE if run=0 (the boundary check uses run at the retire edge).
- Phase counts per class: lw 5, sw 4, add/j/jal 4, each plus wait cycles.
- Wait counter:
  - Cleared on entry to P0/P3; increments each cycle mem_ready=0 in P0/P3.
  - If it reaches MAX_WAIT with mem_ready still 0, go to HALT with cause 10.
  - mem_ready=1 in the same cycle as the limit wins: the phase proceeds.
- mem_ready is ignored outside P0 and P3 (lw/sw).
- run deasserted mid-instruction: the instruction completes, then the sequencer goes to IDLE.
- HALT: p=0, busy=0, halted=1. Leaves HALT only on reset; run has no effect.
- busy=1 in P0..P4.
- cycle_cnt increments every cycle in P0..P4, including wait cycles.
- Both counters wrap to 0 silently.
- op/irfunc/ir hold their value until the next P0 load, and remain valid while halted so the faulting instruction is visible.
- Reset asserted in any state returns to the reset values immediately. No partial instruction is retired.

Decomposition:
- Shared package:
  - phase one-hot constants P0_OH..P4_OH
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_J, OP_JAL) and FUNCT_ADD
  - halt-cause codes
  - the state enum
- The control unit imports the same opcode constants.
- One natural sub-module: instr_class_decode, a combinational decoder from ir to class (add/lw/sw/j/jal/illegal). The control unit can reuse it.

Test Plan:
- Reset, run=1, mem_ready=1, add 0x00221820 → p sequence 00001,00010,00100,10000 then 00001; instr_cnt=1 after 4 cycles.
- lw 0x8C220004 with mem_ready low 3 cycles in P3 → p3 held 4 cycles, total 8 cycles; cycle_cnt=8, instr_cnt=1.
- sw 0xAC220004 → phases p0,p1,p2,p3 only; p never 10000 for that instruction.
- Illegal 0xFC000000 → after p1, p=0, halted=1, halt_cause=01, ir=0xFC000000; further run ignored until reset.
- mem_ready=0 forever in P0, MAX_WAIT=15 → halt_cause=10 after 15 wait cycles. Repeat with mem_ready rising on cycle 15 → proceeds to P1.
- run dropped during p2 of jal 0x0C000010 → p4 completes, p=0, busy=0, instr_cnt=1. Separately, reset pulsed in p3 → all outputs zero asynchronously.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared phase, opcode, class and state definitions
package phase_sequencer_pkg;

  localparam logic [4:0] P0_OH = 5'b00001;
  localparam logic [4:0] P1_OH = 5'b00010;
  localparam logic [4:0] P2_OH = 5'b00100;
  localparam logic [4:0] P3_OH = 5'b01000;
  localparam logic [4:0] P4_OH = 5'b10000;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [2:0] CLS_ADD     = 3'd0;
  localparam logic [2:0] CLS_LW      = 3'd1;
  localparam logic [2:0] CLS_SW      = 3'd2;
  localparam logic [2:0] CLS_J       = 3'd3;
  localparam logic [2:0] CLS_JAL     = 3'd4;
  localparam logic [2:0] CLS_ILLEGAL = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_HALT
  } state_e;

  function automatic logic [4:0] phase_oh(input state_e s);
    case (s)
      S_P0:    phase_oh = P0_OH;
      S_P1:    phase_oh = P1_OH;
      S_P2:    phase_oh = P2_OH;
      S_P3:    phase_oh = P3_OH;
      S_P4:    phase_oh = P4_OH;
      default: phase_oh = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/phase_sequencer_instr_class_decode.sv
// rtl/phase_sequencer_instr_class_decode.sv - combinational opcode/funct to instruction class
module instr_class_decode
  import phase_sequencer_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: if (funct == FUNCT_ADD) cls = CLS_ADD;
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - multi-cycle phase generator with IR, memory stall and halt handling
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      instr_rdata,
  output logic [4:0]       p,
  output logic [5:0]       op,
  output logic [5:0]       irfunc,
  output logic [31:0]      ir,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e     state, state_nx;
  logic [2:0] cls;
  logic [7:0] wait_cnt;
  logic       waiting, wait_limit, retire;
  state_e     boundary;

  assign op     = ir[31:26];
  assign irfunc = ir[5:0];

  instr_class_decode u_decode (
    .op    (ir[31:26]),
    .funct (ir[5:0]),
    .cls   (cls)
  );

  assign waiting    = ((state == S_P0) || (state == S_P3)) && !mem_ready;
  assign wait_limit = waiting && (wait_cnt == WAIT_LAST);
  assign retire     = (state == S_P4) || ((state == S_P3) && mem_ready && (cls == CLS_SW));
  assign boundary   = run ? S_P0 : S_IDLE;

  // p is registered from the next state so the control unit sees a glitch-free one-hot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      p     <= 5'b00000;
    end else begin
      state <= state_nx;
      p     <= phase_oh(state_nx);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (run) state_nx = S_P0;
      S_P0: begin
        if (mem_ready)       state_nx = S_P1;
        else if (wait_limit) state_nx = S_HALT;
      end
      S_P1:   state_nx = (cls == CLS_ILLEGAL) ? S_HALT : S_P2;
      S_P2:   state_nx = ((cls == CLS_LW) || (cls == CLS_SW)) ? S_P3 : S_P4;
      S_P3: begin
        if (mem_ready)       state_nx = (cls == CLS_LW) ? S_P4 : boundary;
        else if (wait_limit) state_nx = S_HALT;
      end
      S_P4:   state_nx = boundary;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    halted = 1'b0;
    case (state)
      S_P0, S_P1, S_P2, S_P3, S_P4: busy = 1'b1;
      S_HALT:                       halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir         <= 32'h0;
      wait_cnt   <= 8'h0;
      halt_cause <= CAUSE_NONE;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
    end else begin
      if ((state == S_P0) && mem_ready) ir <= instr_rdata;
      // any state change is an entry into a fresh phase, so the wait budget restarts
      if (state_nx != state)  wait_cnt <= 8'h0;
      else if (waiting)       wait_cnt <= wait_cnt + 8'h1;
      if ((state_nx == S_HALT) && (state != S_HALT))
        halt_cause <= (state == S_P1) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      if (busy)   cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - vector table with scoreboard plus hand-written corner sequences
module tb_phase_sequencer;

  localparam logic [31:0] I_ADD = 32'h00221820;
  localparam logic [31:0] I_LW  = 32'h8C220004;
  localparam logic [31:0] I_SW  = 32'hAC220004;
  localparam logic [31:0] I_J   = 32'h08000010;
  localparam logic [31:0] I_JAL = 32'h0C000010;
  localparam logic [31:0] I_ILL = 32'hFC000000;
  localparam logic [31:0] I_SUB = 32'h00221822;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] instr_rdata = 32'h0;
  logic [4:0]  p;
  logic [5:0]  op, irfunc;
  logic [31:0] ir;
  logic        busy, halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt, instr_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] instr;
    logic [4:0]  p;
    logic [31:0] ir;
    logic [31:0] cyc;
    logic [31:0] icnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  phase_sequencer #(.MAX_WAIT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready),
    .instr_rdata(instr_rdata), .p(p), .op(op), .irfunc(irfunc), .ir(ir),
    .busy(busy), .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic m, input logic [31:0] ins,
                      input logic [4:0] ep, input logic [31:0] eir,
                      input logic [31:0] ecyc, input logic [31:0] eicnt);
    vec_t v;
    v.run = r; v.mr = m; v.instr = ins; v.p = ep; v.ir = eir; v.cyc = ecyc; v.icnt = eicnt;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; instr_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_p"},      32'(p), 32'h0);
    chk({tag, "_ir"},     ir, 32'h0);
    chk({tag, "_busy"},   32'(busy), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_cause"},  32'(halt_cause), 32'h0);
    chk({tag, "_cyc"},    cycle_cnt, 32'h0);
    chk({tag, "_icnt"},   instr_cnt, 32'h0);
  endtask

  initial begin
    vec_t e;

    // inputs for one cycle, expected outputs after the following rising edge
    addv(1, 1, I_ADD, 5'b00001, 32'h0,  0, 0);
    addv(1, 1, I_ADD, 5'b00010, I_ADD,  1, 0);
    addv(1, 1, I_ADD, 5'b00100, I_ADD,  2, 0);
    addv(1, 1, I_ADD, 5'b10000, I_ADD,  3, 0);
    addv(1, 1, I_ADD, 5'b00001, I_ADD,  4, 1);
    addv(1, 1, I_LW,  5'b00010, I_LW,   5, 1);
    addv(1, 1, I_LW,  5'b00100, I_LW,   6, 1);
    addv(1, 1, I_LW,  5'b01000, I_LW,   7, 1);
    addv(1, 0, I_LW,  5'b01000, I_LW,   8, 1);
    addv(1, 0, I_LW,  5'b01000, I_LW,   9, 1);
    addv(1, 0, I_LW,  5'b01000, I_LW,  10, 1);
    addv(1, 1, I_LW,  5'b10000, I_LW,  11, 1);
    addv(1, 1, I_LW,  5'b00001, I_LW,  12, 2);
    addv(1, 1, I_SW,  5'b00010, I_SW,  13, 2);
    addv(1, 1, I_SW,  5'b00100, I_SW,  14, 2);
    addv(1, 1, I_SW,  5'b01000, I_SW,  15, 2);
    addv(1, 1, I_SW,  5'b00001, I_SW,  16, 3);
    addv(1, 1, I_JAL, 5'b00010, I_JAL, 17, 3);
    addv(1, 1, I_JAL, 5'b00100, I_JAL, 18, 3);
    addv(0, 1, I_JAL, 5'b10000, I_JAL, 19, 3);
    addv(0, 1, I_JAL, 5'b00000, I_JAL, 20, 4);
    addv(0, 1, I_JAL, 5'b00000, I_JAL, 20, 4);
    addv(1, 0, I_J,   5'b00001, I_JAL, 20, 4);
    addv(1, 0, I_J,   5'b00001, I_JAL, 21, 4);
    addv(1, 1, I_J,   5'b00010, I_J,   22, 4);
    addv(1, 0, I_J,   5'b00100, I_J,   23, 4);
    addv(1, 0, I_J,   5'b10000, I_J,   24, 4);
    addv(0, 0, I_J,   5'b00000, I_J,   25, 5);

    do_reset();
    chk_idle_zero("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      run = tbl[i].run; mem_ready = tbl[i].mr; instr_rdata = tbl[i].instr;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_p", i),      32'(p), 32'(e.p));
      chk($sformatf("v%0d_busy", i),   32'(busy), 32'(e.p != 5'b0));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'h0);
      chk($sformatf("v%0d_ir", i),     ir, e.ir);
      chk($sformatf("v%0d_op", i),     32'(op), 32'(e.ir[31:26]));
      chk($sformatf("v%0d_func", i),   32'(irfunc), 32'(e.ir[5:0]));
      chk($sformatf("v%0d_cyc", i),    cycle_cnt, e.cyc);
      chk($sformatf("v%0d_icnt", i),   instr_cnt, e.icnt);
    end

    // illegal opcode halts after decode and ignores run afterwards
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_rdata = I_ILL;
    repeat (2) @(negedge clk);
    chk("ill_p1", 32'(p), 32'(5'b00010));
    @(negedge clk);
    chk("ill_p",      32'(p), 32'h0);
    chk("ill_halted", 32'(halted), 32'h1);
    chk("ill_busy",   32'(busy), 32'h0);
    chk("ill_cause",  32'(halt_cause), 32'h1);
    chk("ill_ir",     ir, I_ILL);
    chk("ill_op",     32'(op), 32'h3F);
    instr_rdata = I_ADD;
    repeat (5) @(negedge clk);
    chk("ill_stay_p",      32'(p), 32'h0);
    chk("ill_stay_halted", 32'(halted), 32'h1);
    chk("ill_stay_ir",     ir, I_ILL);
    chk("ill_stay_cyc",    cycle_cnt, 32'd2);
    chk("ill_stay_icnt",   instr_cnt, 32'h0);

    // R-type with a non-add funct is also illegal
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_rdata = I_SUB;
    repeat (3) @(negedge clk);
    chk("sub_halted", 32'(halted), 32'h1);
    chk("sub_cause",  32'(halt_cause), 32'h1);

    // fetch never acknowledged: halt at the end of the 15th wait cycle
    do_reset();
    run = 1'b1; mem_ready = 1'b0; instr_rdata = I_ADD;
    @(negedge clk);
    repeat (14) @(negedge clk);
    chk("to_pre_p",      32'(p), 32'(5'b00001));
    chk("to_pre_halted", 32'(halted), 32'h0);
    chk("to_pre_cyc",    cycle_cnt, 32'd14);
    @(negedge clk);
    chk("to_p",      32'(p), 32'h0);
    chk("to_halted", 32'(halted), 32'h1);
    chk("to_cause",  32'(halt_cause), 32'h2);
    chk("to_cyc",    cycle_cnt, 32'd15);
    chk("to_ir",     ir, 32'h0);

    // acknowledge arrives on the limit cycle: the fetch proceeds
    do_reset();
    run = 1'b1; mem_ready = 1'b0; instr_rdata = I_ADD;
    @(negedge clk);
    repeat (14) @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rec_p",      32'(p), 32'(5'b00010));
    chk("rec_halted", 32'(halted), 32'h0);
    chk("rec_ir",     ir, I_ADD);

    // asynchronous reset while a lw is stalled in P3
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_rdata = I_LW;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst3_p",  32'(p), 32'(5'b01000));
    chk("rst3_ir", ir, I_LW);
    #2 reset = 1'b1;
    #1 chk_idle_zero("rst3_async");
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
